// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm, wait for a trigger, optional post-trigger delay,
// then hold capture_go_o while counting tuple writes until the limit or a FIFO overflow.
module adc_capture_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 adc_sampleclk,
    input  logic                 ddr_usrreset,
    input  logic                 arm_i,
    input  logic                 trig_i,
    input  logic [1:0]           trig_mode_i,
    input  logic [CNT_WIDTH-1:0] trig_offset_i,
    input  logic [CNT_WIDTH-1:0] max_tuples_i,
    input  logic                 tuple_wr_i,
    input  logic                 fifo_full_i,
    output logic                 capture_go_o,
    output logic                 trig_status_o,
    output logic [2:0]           state_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [CNT_WIDTH-1:0] tuple_count_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        DELAY   = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] arm_sync, trig_sync;
    logic                   arm_s, arm_d, trig_s, trig_d;
    logic                   arm_rise, trig_event;
    logic [CNT_WIDTH-1:0]   count, count_nxt, count_inc;
    logic [CNT_WIDTH-1:0]   max_l, max_nxt, off_l, off_nxt, dly, dly_nxt;
    logic                   overflow, overflow_nxt;
    logic                   capture_go, done;

    // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
    always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
        if (ddr_usrreset) begin
            arm_sync  <= '0;
            trig_sync <= '0;
            arm_d     <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            arm_sync  <= {arm_sync[SYNC_STAGES-2:0], arm_i};
            trig_sync <= {trig_sync[SYNC_STAGES-2:0], trig_i};
            arm_d     <= arm_s;
            trig_d    <= trig_s;
        end
    end

    assign arm_s     = arm_sync[SYNC_STAGES-1];
    assign trig_s    = trig_sync[SYNC_STAGES-1];
    assign arm_rise  = arm_s & ~arm_d;
    assign count_inc = (count == '1) ? count : count + CNT_WIDTH'(1);

    always_comb begin
        case (trig_mode_i)
            2'b00:   trig_event = trig_s & ~trig_d;
            2'b01:   trig_event = ~trig_s & trig_d;
            2'b10:   trig_event = trig_s;
            default: trig_event = ~trig_s;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        overflow_nxt = overflow;
        max_nxt      = max_l;
        off_nxt      = off_l;
        dly_nxt      = dly;
        case (state)
            IDLE: begin
                if (arm_rise) begin
                    state_nxt    = ARMED;
                    count_nxt    = '0;
                    overflow_nxt = 1'b0;
                    max_nxt      = max_tuples_i;
                    off_nxt      = trig_offset_i;
                end
            end
            ARMED: begin
                if (!arm_s) begin
                    state_nxt = IDLE;
                end else if (trig_event) begin
                    if (max_l == '0) begin
                        state_nxt = DONE;
                    end else if (off_l == '0) begin
                        state_nxt = CAPTURE;
                    end else begin
                        state_nxt = DELAY;
                        dly_nxt   = off_l - CNT_WIDTH'(1);
                    end
                end
            end
            DELAY: begin
                if (!arm_s) begin
                    state_nxt = IDLE;
                end else if (dly == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    dly_nxt = dly - CNT_WIDTH'(1);
                end
            end
            CAPTURE: begin
                // Disarm outranks the tuple write: that tuple is neither counted nor completes the run.
                if (!arm_s) begin
                    state_nxt = IDLE;
                end else if (tuple_wr_i) begin
                    count_nxt = count_inc;
                    if (fifo_full_i) begin
                        overflow_nxt = 1'b1;
                        state_nxt    = DONE;
                    end else if (count_inc == max_l) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!arm_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge adc_sampleclk or posedge ddr_usrreset) begin
        if (ddr_usrreset) begin
            state      <= IDLE;
            count      <= '0;
            overflow   <= 1'b0;
            max_l      <= '0;
            off_l      <= '0;
            dly        <= '0;
            capture_go <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            overflow   <= overflow_nxt;
            max_l      <= max_nxt;
            off_l      <= off_nxt;
            dly        <= dly_nxt;
            // Registered from the next state so the level tracks CAPTURE with no decode glitches.
            capture_go <= (state_nxt == CAPTURE);
            done       <= (state_nxt == DONE);
        end
    end

    assign capture_go_o  = capture_go;
    assign trig_status_o = trig_s;
    assign state_o       = state;
    assign done_o        = done;
    assign overflow_o    = overflow;
    assign tuple_count_o = count;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scenario bench for adc_capture_ctrl; expectations are derived arithmetically from
// synchronizer depth, trigger offset, tuple limits and overflow position.
module tb_adc_capture_ctrl;

    localparam int SYNC = 2;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm_i, trig_i, tuple_wr_i, fifo_full_i;
    logic [1:0]    trig_mode_i;
    logic [CW-1:0] trig_offset_i, max_tuples_i;
    logic          capture_go_o, trig_status_o, done_o, overflow_o;
    logic [2:0]    state_o;
    logic [CW-1:0] tuple_count_o;

    int checks   = 0;
    int failures = 0;

    adc_capture_ctrl #(.SYNC_STAGES(SYNC), .CNT_WIDTH(CW)) dut (
        .adc_sampleclk (clk),
        .ddr_usrreset  (rst),
        .arm_i         (arm_i),
        .trig_i        (trig_i),
        .trig_mode_i   (trig_mode_i),
        .trig_offset_i (trig_offset_i),
        .max_tuples_i  (max_tuples_i),
        .tuple_wr_i    (tuple_wr_i),
        .fifo_full_i   (fifo_full_i),
        .capture_go_o  (capture_go_o),
        .trig_status_o (trig_status_o),
        .state_o       (state_o),
        .done_o        (done_o),
        .overflow_o    (overflow_o),
        .tuple_count_o (tuple_count_o)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs observed on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tuple(input logic full);
        tuple_wr_i  = 1'b1;
        fifo_full_i = full;
        cycles(1);
        tuple_wr_i  = 1'b0;
        fifo_full_i = 1'b0;
    endtask

    // Cycles from now until capture_go_o is first seen high; -1 when the bound expires.
    task automatic wait_go(output int lat);
        lat = -1;
        for (int i = 1; i <= 300 && lat < 0; i++) begin
            cycles(1);
            if (capture_go_o === 1'b1) lat = i;
        end
    endtask

    // Returns once the synchronized arm has moved the controller to ARMED.
    task automatic do_arm(input logic [1:0] mode, input int off, input int mx);
        trig_mode_i   = mode;
        trig_offset_i = CW'(off);
        max_tuples_i  = CW'(mx);
        arm_i         = 1'b1;
        cycles(SYNC + 1);
    endtask

    task automatic disarm();
        arm_i = 1'b0;
        cycles(SYNC + 2);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycles(3);
        checks++; if (capture_go_o !== 1'b0) begin failures++; $display("FAIL reset_go got=%b want=0", capture_go_o); end
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", state_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done_o); end
        checks++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow_o); end
        checks++; if (tuple_count_o !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", tuple_count_o); end
        checks++; if (trig_status_o !== 1'b0) begin failures++; $display("FAIL reset_trig_status got=%b want=0", trig_status_o); end
        rst = 1'b0;
        cycles(4);
        checks++; if (state_o !== 3'd0) begin failures++; $display("FAIL idle_no_arm got=%0d want=0", state_o); end
    endtask

    task automatic test_rising_edge();
        int mx, off, gap, lat;
        for (int it = 0; it < 4; it++) begin
            mx  = (it == 0) ? 4 : int'($urandom_range(1, 8));
            off = (it == 0) ? 0 : int'($urandom_range(0, 6));
            gap = (it == 0) ? 3 : int'($urandom_range(1, 4));
            trig_i = 1'b0;
            do_arm(2'b00, off, mx);
            checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL rise_armed it=%0d got=%0d want=1", it, state_o); end
            trig_i = 1'b1;
            wait_go(lat);
            trig_i = 1'b0;
            checks++; if (lat != SYNC + 1 + off) begin failures++; $display("FAIL rise_latency it=%0d got=%0d want=%0d", it, lat, SYNC + 1 + off); end
            for (int t = 1; t <= mx; t++) begin
                cycles(gap - 1);
                checks++; if (capture_go_o !== 1'b1) begin failures++; $display("FAIL rise_go_high it=%0d t=%0d got=%b want=1", it, t, capture_go_o); end
                pulse_tuple(1'b0);
                checks++; if (tuple_count_o !== CW'(t)) begin failures++; $display("FAIL rise_count it=%0d got=%0d want=%0d", it, tuple_count_o, t); end
            end
            checks++; if (capture_go_o !== 1'b0) begin failures++; $display("FAIL rise_go_fall it=%0d got=%b want=0", it, capture_go_o); end
            checks++; if (done_o !== 1'b1) begin failures++; $display("FAIL rise_done it=%0d got=%b want=1", it, done_o); end
            checks++; if (state_o !== 3'd4) begin failures++; $display("FAIL rise_state it=%0d got=%0d want=4", it, state_o); end
            pulse_tuple(1'b0);
            checks++; if (tuple_count_o !== CW'(mx)) begin failures++; $display("FAIL rise_ignored_wr it=%0d got=%0d want=%0d", it, tuple_count_o, mx); end
            disarm();
            checks++; if (state_o !== 3'd0 || done_o !== 1'b0) begin failures++; $display("FAIL rise_release it=%0d state=%0d done=%b want 0/0", it, state_o, done_o); end
        end
    endtask

    task automatic test_falling_edge();
        int lat;
        trig_i = 1'b0;
        do_arm(2'b01, 10, 5);
        trig_i = 1'b1;
        cycles(SYNC - 1);
        checks++; if (trig_status_o !== 1'b0) begin failures++; $display("FAIL trig_status_early got=%b want=0", trig_status_o); end
        cycles(1);
        checks++; if (trig_status_o !== 1'b1) begin failures++; $display("FAIL trig_status got=%b want=1", trig_status_o); end
        cycles(6);
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL fall_rise_ignored got=%0d want=1", state_o); end
        trig_i = 1'b0;
        wait_go(lat);
        checks++; if (lat != SYNC + 1 + 10) begin failures++; $display("FAIL fall_latency got=%0d want=%0d", lat, SYNC + 11); end
        checks++; if (state_o !== 3'd3) begin failures++; $display("FAIL fall_capture got=%0d want=3", state_o); end
        arm_i = 1'b0;
        cycles(SYNC);
        checks++; if (capture_go_o !== 1'b1) begin failures++; $display("FAIL disarm_early got=%b want=1", capture_go_o); end
        cycles(1);
        checks++; if (state_o !== 3'd0 || capture_go_o !== 1'b0) begin failures++; $display("FAIL disarm_idle state=%0d go=%b want 0/0", state_o, capture_go_o); end
        cycles(2);
    endtask

    task automatic test_level();
        int lat;
        trig_i = 1'b1;
        cycles(SYNC + 2);
        do_arm(2'b10, 0, 3);
        checks++; if (state_o !== 3'd1) begin failures++; $display("FAIL level_hi_armed got=%0d want=1", state_o); end
        cycles(1);
        checks++; if (state_o !== 3'd3 || capture_go_o !== 1'b1) begin failures++; $display("FAIL level_hi_capture state=%0d go=%b want 3/1", state_o, capture_go_o); end
        disarm();
        do_arm(2'b11, 0, 3);
        cycles(5);
        checks++; if (state_o !== 3'd1 || capture_go_o !== 1'b0) begin failures++; $display("FAIL level_lo_wait state=%0d go=%b want 1/0", state_o, capture_go_o); end
        trig_i = 1'b0;
        wait_go(lat);
        checks++; if (lat != SYNC + 1) begin failures++; $display("FAIL level_lo_latency got=%0d want=%0d", lat, SYNC + 1); end
        disarm();
    endtask

    task automatic test_overflow();
        int lat, off;
        off = int'($urandom_range(0, 4));
        trig_i = 1'b0;
        do_arm(2'b00, off, 100);
        trig_i = 1'b1;
        wait_go(lat);
        trig_i = 1'b0;
        checks++; if (lat != SYNC + 1 + off) begin failures++; $display("FAIL ovf_latency got=%0d want=%0d", lat, SYNC + 1 + off); end
        for (int t = 1; t <= 37; t++) begin
            cycles(int'($urandom_range(0, 2)));
            pulse_tuple(t == 37);
        end
        checks++; if (overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", overflow_o); end
        checks++; if (tuple_count_o !== CW'(37)) begin failures++; $display("FAIL ovf_count got=%0d want=37", tuple_count_o); end
        checks++; if (state_o !== 3'd4 || capture_go_o !== 1'b0 || done_o !== 1'b1) begin failures++; $display("FAIL ovf_done state=%0d go=%b done=%b want 4/0/1", state_o, capture_go_o, done_o); end
        arm_i = 1'b0;
        cycles(SYNC + 1);
        checks++; if (state_o !== 3'd0 || overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky state=%0d ovf=%b want 0/1", state_o, overflow_o); end
        do_arm(2'b00, 0, 100);
        checks++; if (overflow_o !== 1'b0 || tuple_count_o !== '0) begin failures++; $display("FAIL rearm_clear ovf=%b count=%0d want 0/0", overflow_o, tuple_count_o); end
        disarm();
        // Overflow on the tuple that also completes the count.
        do_arm(2'b00, 0, 3);
        trig_i = 1'b1;
        wait_go(lat);
        trig_i = 1'b0;
        pulse_tuple(1'b0);
        pulse_tuple(1'b0);
        pulse_tuple(1'b1);
        checks++; if (state_o !== 3'd4 || overflow_o !== 1'b1 || tuple_count_o !== CW'(3)) begin failures++; $display("FAIL ovf_and_complete state=%0d ovf=%b count=%0d want 4/1/3", state_o, overflow_o, tuple_count_o); end
        disarm();
    endtask

    task automatic test_disarm_complete();
        int mx, lat;
        mx = int'($urandom_range(2, 6));
        trig_i = 1'b0;
        do_arm(2'b00, 0, mx);
        trig_i = 1'b1;
        wait_go(lat);
        trig_i = 1'b0;
        for (int t = 1; t < mx; t++) pulse_tuple(1'b0);
        arm_i = 1'b0;
        cycles(SYNC);
        tuple_wr_i = 1'b1;
        cycles(1);
        tuple_wr_i = 1'b0;
        checks++; if (state_o !== 3'd0 || done_o !== 1'b0 || capture_go_o !== 1'b0) begin failures++; $display("FAIL disarm_wins state=%0d done=%b go=%b want 0/0/0", state_o, done_o, capture_go_o); end
        checks++; if (tuple_count_o !== CW'(mx - 1)) begin failures++; $display("FAIL disarm_count got=%0d want=%0d", tuple_count_o, mx - 1); end
        cycles(2);
    endtask

    task automatic test_max_zero();
        logic seen_go;
        seen_go = 1'b0;
        trig_i = 1'b0;
        do_arm(2'b00, int'($urandom_range(0, 3)), 0);
        trig_i = 1'b1;
        for (int i = 0; i < SYNC + 1; i++) begin
            cycles(1);
            if (capture_go_o !== 1'b0) seen_go = 1'b1;
        end
        checks++; if (state_o !== 3'd4 || done_o !== 1'b1) begin failures++; $display("FAIL max0_done state=%0d done=%b want 4/1", state_o, done_o); end
        for (int i = 0; i < 8; i++) begin
            cycles(1);
            if (capture_go_o !== 1'b0) seen_go = 1'b1;
        end
        checks++; if (seen_go !== 1'b0) begin failures++; $display("FAIL max0_go got=%b want=0", seen_go); end
        trig_i = 1'b0;
        disarm();
    endtask

    task automatic test_reset_mid();
        int lat;
        trig_i = 1'b0;
        do_arm(2'b00, 50, 5);
        trig_i = 1'b1;
        cycles(SYNC + 3);
        checks++; if (state_o !== 3'd2) begin failures++; $display("FAIL delay_state got=%0d want=2", state_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (state_o !== 3'd0 || capture_go_o !== 1'b0 || done_o !== 1'b0 || overflow_o !== 1'b0 || tuple_count_o !== '0 || trig_status_o !== 1'b0) begin
            failures++; $display("FAIL reset_in_delay state=%0d go=%b done=%b ovf=%b count=%0d trig=%b want all 0", state_o, capture_go_o, done_o, overflow_o, tuple_count_o, trig_status_o);
        end
        arm_i  = 1'b0;
        trig_i = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(2);
        do_arm(2'b00, 0, 10);
        trig_i = 1'b1;
        wait_go(lat);
        trig_i = 1'b0;
        pulse_tuple(1'b0);
        pulse_tuple(1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (capture_go_o !== 1'b0 || tuple_count_o !== '0 || state_o !== 3'd0) begin failures++; $display("FAIL reset_in_capture go=%b count=%0d state=%0d want 0/0/0", capture_go_o, tuple_count_o, state_o); end
        arm_i = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(2);
    endtask

    initial begin
        rst           = 1'b1;
        arm_i         = 1'b0;
        trig_i        = 1'b0;
        trig_mode_i   = 2'b00;
        trig_offset_i = '0;
        max_tuples_i  = '0;
        tuple_wr_i    = 1'b0;
        fifo_full_i   = 1'b0;
        test_reset();
        test_rising_edge();
        test_falling_edge();
        test_level();
        test_overflow();
        test_disarm_complete();
        test_max_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
